ma_stage_mc: RTL

Parametrised memory-access pipeline stage with a multi-cycle data-memory handshake. It sits between the EX/MA and WB stages of the RV32I core. It accepts one instruction per cycle from EX, issues loads and stores to a data-memory port with valid/ready and response-valid signalling, and stalls upstream while an access is outstanding. It also formats load data per `funct3`, generates store byte strobes, flags misaligned accesses and bus timeouts, and registers the MA/WB pipeline outputs with a valid bit.

---
 rtl/ma_stage_mc.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/ma_stage_mc.sv
// ma_stage_mc: RV32I memory-access pipeline stage with a multi-cycle
// valid/ready data-memory handshake.
// Ports:
//   clk, reset                   clock and synchronous active-high reset
//   in_valid / in_ready          EX/MA instruction handshake (in_ready=0 stalls EX)
//   *_in                         EX/MA pipeline fields
//   mem_req_* / mem_we / mem_*   data-memory request channel (word-aligned address)
//   mem_rsp_valid / mem_rdata    data-memory load response
//   wb_valid, *_out              registered MA/WB pipeline outputs
//   misalign_out, bus_err_out    exception flags, qualified by wb_valid
module ma_stage_mc #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                RegWEn_in,
    input  logic                MemEn_in,
    input  logic                MemRW_in,
    input  logic [1:0]          WBSel_in,
    input  logic [2:0]          funct3_in,
    input  logic [4:0]          AddrD_in,
    input  logic [XLEN-1:0]     ALU_Result_in,
    input  logic [XLEN-1:0]     DataW_in,
    input  logic [XLEN-1:0]     pcPlus4_in,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [XLEN-1:0]     mem_wdata,
    output logic [XLEN/8-1:0]   mem_wstrb,
    input  logic                mem_rsp_valid,
    input  logic [XLEN-1:0]     mem_rdata,
    output logic                wb_valid,
    output logic                RegWEn_out,
    output logic [1:0]          WBSel_out,
    output logic [4:0]          AddrD_out,
    output logic [XLEN-1:0]     DataR_out,
    output logic [XLEN-1:0]     ALU_Result_out,
    output logic [XLEN-1:0]     pcPlus4_out,
    output logic                misalign_out,
    output logic                bus_err_out
);

    localparam int unsigned STRB_W = XLEN / 8;
    localparam int unsigned CNT_W  = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;

    // Captured instruction fields for the multi-cycle path
    logic               h_regwen;
    logic [1:0]         h_wbsel;
    logic [4:0]         h_addrd;
    logic [2:0]         h_f3;
    logic [XLEN-1:0]    h_alu;
    logic [XLEN-1:0]    h_pc4;

    // Combinational helpers
    logic [1:0]         off_in;
    logic [1:0]         h_off;
    logic               misalign_c;
    logic [XLEN-1:0]    wdata_c;
    logic [STRB_W-1:0]  wstrb_c;
    logic [ADDR_W-1:0]  addr_c;
    logic [7:0]         rbyte_c;
    logic [15:0]        rhalf_c;
    logic [XLEN-1:0]    load_c;

    assign in_ready = (state == IDLE);

    // Alignment check, store formatting and load formatting
    always_comb begin
        off_in     = ALU_Result_in[1:0];
        h_off      = h_alu[1:0];
        misalign_c = 1'b0;
        case (funct3_in[1:0])
            2'b01:   misalign_c = off_in[0];
            2'b10:   misalign_c = (off_in != 2'b00);
            default: misalign_c = 1'b0;
        endcase

        wdata_c = DataW_in;
        wstrb_c = '1;
        case (funct3_in[1:0])
            2'b00: begin
                wdata_c = {4{DataW_in[7:0]}};
                wstrb_c = STRB_W'(1) << off_in;
            end
            2'b01: begin
                wdata_c = {2{DataW_in[15:0]}};
                wstrb_c = STRB_W'(3) << off_in;
            end
            default: ;
        endcase

        addr_c      = ADDR_W'(ALU_Result_in);
        addr_c[1:0] = 2'b00;

        rbyte_c = 8'(mem_rdata >> {h_off, 3'b000});
        rhalf_c = 16'(mem_rdata >> {h_off[1], 4'b0000});
        case (h_f3)
            3'b000:  load_c = {{(XLEN-8){rbyte_c[7]}}, rbyte_c};
            3'b001:  load_c = {{(XLEN-16){rhalf_c[15]}}, rhalf_c};
            3'b100:  load_c = {{(XLEN-8){1'b0}}, rbyte_c};
            3'b101:  load_c = {{(XLEN-16){1'b0}}, rhalf_c};
            default: load_c = mem_rdata;
        endcase
    end

    // FSM, memory request registers and MA/WB output register
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            cnt            <= '0;
            mem_req_valid  <= 1'b0;
            mem_we         <= 1'b0;
            mem_addr       <= '0;
            mem_wdata      <= '0;
            mem_wstrb      <= '0;
            h_regwen       <= 1'b0;
            h_wbsel        <= '0;
            h_addrd        <= '0;
            h_f3           <= '0;
            h_alu          <= '0;
            h_pc4          <= '0;
            wb_valid       <= 1'b0;
            RegWEn_out     <= 1'b0;
            WBSel_out      <= '0;
            AddrD_out      <= '0;
            DataR_out      <= '0;
            ALU_Result_out <= '0;
            pcPlus4_out    <= '0;
            misalign_out   <= 1'b0;
            bus_err_out    <= 1'b0;
        end else begin
            wb_valid   <= 1'b0;
            RegWEn_out <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (!MemEn_in || misalign_c) begin
                            // Retire directly; misaligned accesses never reach the bus
                            wb_valid       <= 1'b1;
                            RegWEn_out     <= RegWEn_in && !MemEn_in;
                            WBSel_out      <= WBSel_in;
                            AddrD_out      <= AddrD_in;
                            DataR_out      <= '0;
                            ALU_Result_out <= ALU_Result_in;
                            pcPlus4_out    <= pcPlus4_in;
                            misalign_out   <= MemEn_in;
                            bus_err_out    <= 1'b0;
                        end else begin
                            h_regwen      <= RegWEn_in;
                            h_wbsel       <= WBSel_in;
                            h_addrd       <= AddrD_in;
                            h_f3          <= funct3_in;
                            h_alu         <= ALU_Result_in;
                            h_pc4         <= pcPlus4_in;
                            mem_req_valid <= 1'b1;
                            mem_we        <= MemRW_in;
                            mem_addr      <= addr_c;
                            mem_wdata     <= wdata_c;
                            mem_wstrb     <= MemRW_in ? wstrb_c : '0;
                            state         <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        cnt           <= '0;
                        if (mem_we) begin
                            wb_valid       <= 1'b1;
                            WBSel_out      <= h_wbsel;
                            AddrD_out      <= h_addrd;
                            DataR_out      <= '0;
                            ALU_Result_out <= h_alu;
                            pcPlus4_out    <= h_pc4;
                            misalign_out   <= 1'b0;
                            bus_err_out    <= 1'b0;
                            state          <= IDLE;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    // A response in the final counted cycle takes priority over the timeout
                    if (mem_rsp_valid || (cnt == CNT_W'(TIMEOUT - 1))) begin
                        wb_valid       <= 1'b1;
                        RegWEn_out     <= mem_rsp_valid && h_regwen;
                        WBSel_out      <= h_wbsel;
                        AddrD_out      <= h_addrd;
                        DataR_out      <= mem_rsp_valid ? load_c : '0;
                        ALU_Result_out <= h_alu;
                        pcPlus4_out    <= h_pc4;
                        misalign_out   <= 1'b0;
                        bus_err_out    <= !mem_rsp_valid;
                        cnt            <= '0;
                        state          <= IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
